// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    // Widest operand the magnitude helper handles (WIDTH must stay below this).
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    function automatic logic [MAX_W-1:0] abs_twos(input logic [MAX_W-1:0] val,
                                                  input logic             is_neg);
        return is_neg ? (~val + MAX_W'(1)) : val;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH:0]     i_rem,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH:0]     o_rem
);

    localparam int AW = 2 * WIDTH;
    localparam int RW = WIDTH + 1;
    localparam int SW = WIDTH + 2;

    logic [RW-1:0] w_sum;
    logic [SW-1:0] w_shift;
    logic          w_ge;

    assign w_sum   = {1'b0, i_acc[AW-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Dividend bits leave the top of the low half and enter the remainder.
    assign w_shift = {i_rem, i_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= SW'(i_opnd));

    always_comb begin
        o_acc = i_acc;
        o_rem = i_rem;
        if (i_div) begin
            o_acc = {i_acc[AW-1:WIDTH], i_acc[WIDTH-2:0], w_ge};
            o_rem = w_ge ? RW'(w_shift - SW'(i_opnd)) : w_shift[RW-1:0];
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// States: IDLE wait for start | RUN one step per cycle | FIX sign-correct, write HI/LO | DONE pulse done
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int AW    = 2 * WIDTH;
    localparam int RW    = WIDTH + 1;

    state_e           r_state;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_acc;
    logic [RW-1:0]    r_rem;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic                   w_signed;
    logic                   w_lhs_neg;
    logic                   w_rhs_neg;
    logic [WIDTH-1:0]       w_lhs_mag;
    logic [WIDTH-1:0]       w_rhs_mag;
    logic [MAX_W-WIDTH-1:0] w_unused_lhs;
    logic [MAX_W-WIDTH-1:0] w_unused_rhs;
    logic                   w_rhs_zero;
    logic [AW-1:0]          w_acc_nxt;
    logic [RW-1:0]          w_rem_nxt;
    logic [AW-1:0]          w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem_fix;

    // MULT and DIV are the signed encodings (op[0] clear).
    assign w_signed   = ~op[0];
    assign w_lhs_neg  = w_signed & lhs[WIDTH-1];
    assign w_rhs_neg  = w_signed & rhs[WIDTH-1];
    assign {w_unused_lhs, w_lhs_mag} = abs_twos(MAX_W'(lhs), w_lhs_neg);
    assign {w_unused_rhs, w_rhs_mag} = abs_twos(MAX_W'(rhs), w_rhs_neg);
    assign w_rhs_zero = (rhs == '0);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_is_div),
        .i_acc  (r_acc),
        .i_rem  (r_rem),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_rem  (w_rem_nxt)
    );

    assign w_prod    = r_neg_res ? (~r_acc + AW'(1)) : r_acc;
    assign w_quo     = r_neg_res ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    assign w_rem_fix = r_neg_rem ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div   <= op[1];
                        r_neg_res  <= w_lhs_neg ^ w_rhs_neg;
                        r_neg_rem  <= w_lhs_neg;
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rem      <= '0;
                        if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_lhs_mag};
                            r_opnd <= w_rhs_mag;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_rhs_mag};
                            r_opnd <= w_lhs_mag;
                        end
                        if (op[1] && w_rhs_zero) begin
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_cnt   <= CNT_W'(WIDTH);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[AW-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a queue of expected HI/LO results.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] m_hi     = '0;
    logic [W-1:0] m_lo     = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .lhs      (lhs),
        .rhs      (rhs),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference results from wide native arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] l, input logic [W-1:0] r);
        exp_t               e;
        logic signed [63:0] sl;
        logic signed [63:0] sr;
        logic signed [63:0] p;
        logic [63:0]        u;
        e.dz = 1'b0;
        e.hi = m_hi;
        e.lo = m_lo;
        sl = $signed(l);
        sr = $signed(r);
        case (o)
            2'b00: begin
                p = sl * sr;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                u = {32'b0, l} * {32'b0, r};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            2'b10: begin
                if (r == '0) e.dz = 1'b1;
                else begin
                    p = sl / sr;
                    e.lo = p[31:0];
                    p = sl % sr;
                    e.hi = p[31:0];
                end
            end
            default: begin
                if (r == '0) e.dz = 1'b1;
                else begin
                    e.lo = l / r;
                    e.hi = l % r;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] l, input logic [W-1:0] r,
                          input int exp_lat, input int inject, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        int   extra;
        e = model(o, l, r);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        op = o; lhs = l; rhs = r; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        k = 1;
        start = 1'b0;
        lhs = $urandom;
        rhs = $urandom;
        op  = 2'($urandom);
        check({tag, "_busy"}, W'(busy), W'(1));
        while (done !== 1'b1 && k < 200) begin
            start = (k == inject);
            @(negedge Clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, W'(k), W'(exp_lat));
        got = sb.pop_front();
        check({tag, "_hi"}, hi, got.hi);
        check({tag, "_lo"}, lo, got.lo);
        check({tag, "_div_zero"}, W'(div_zero), W'(got.dz));
        @(negedge Clk);
        check({tag, "_done_pulse"}, W'(done), W'(0));
        check({tag, "_busy_after"}, W'(busy), W'(0));
        if (inject > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge Clk);
                if (done === 1'b1) extra++;
            end
            check({tag, "_extra_done"}, W'(extra), W'(0));
        end
    endtask

    task automatic mt(input logic to_hi, input logic [W-1:0] v);
        hi_we = to_hi;
        lo_we = ~to_hi;
        wdata = v;
        @(negedge Clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (to_hi) m_hi = v;
        else       m_lo = v;
        check(to_hi ? "mthi" : "mtlo", to_hi ? hi : lo, v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; lhs = '0; rhs = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_div_zero", W'(div_zero), W'(0));
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 34, 0, "mult_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 34, 0, "div_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 34, 0, "divu");
        mt(1'b1, 32'h0000_0011);
        mt(1'b0, 32'h0000_0022);
        run_op(2'b11, 32'd100, 32'd0, 1, 0, "divu_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 5, "div_min");

        // Abort a MULT partway through RUN.
        op = 2'b00; lhs = 32'd3; rhs = 32'd5; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        run_op(2'b00, 32'd6, 32'd7, 34, 0, "mult_6x7");

        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), 32'($urandom), 32'($urandom) | 32'h1, 34, 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
